// File: rtl/tagged_multicaster.sv
// Tag-keyed multicaster: buffers tagged words and delivers each one to every
// destination whose key matches, with independent per-destination handshakes.
// Latency: a word pushed into an empty FIFO in IDLE at edge N drives out_valid after edge N+1.
// Backpressure: in_ready = FIFO not full; the head word stays until every matched destination takes it.
//
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   cfg_we, cfg_idx, cfg_tag    - per-destination key write (out-of-range index ignored)
//   in_valid/in_ready           - source handshake; in_data, in_tag, in_mask, in_mode describe the word
//   out_valid/out_ready         - per-destination handshake; out_data is shared by all destinations
//   busy                        - FIFO non-empty or a word in delivery
//   drop_cnt                    - saturating count of words that matched no destination
module tagged_multicaster #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DEST   = 4,
    parameter int TAG_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int IDX_W     = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [TAG_WIDTH-1:0]  cfg_tag,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    input  logic [TAG_WIDTH-1:0]  in_mask,
    input  logic [1:0]            in_mode,
    output logic [NUM_DEST-1:0]   out_valid,
    input  logic [NUM_DEST-1:0]   out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic [7:0]            drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        DELIVER = 1'b1
    } state_t;

    state_t                state;
    logic [NUM_DEST-1:0]   pending;
    logic [TAG_WIDTH-1:0]  key [NUM_DEST];

    // Input buffer storage; contents need no reset because occupancy gates every read.
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]  mem_tag  [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]  mem_mask [FIFO_DEPTH];
    logic [1:0]            mem_mode [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;

    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic [NUM_DEST-1:0]   match;
    logic [NUM_DEST-1:0]   remaining;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign in_ready  = !full;
    assign push      = in_valid && in_ready;
    assign remaining = pending & ~out_ready;

    // Head leaves the FIFO either when it is dropped in IDLE or when the last
    // outstanding destination handshakes in DELIVER.
    assign pop = !empty &&
                 (((state == IDLE) && (match == '0)) ||
                  ((state == DELIVER) && (remaining == '0)));

    assign out_valid = pending;
    assign busy      = (state == DELIVER) || !empty;

    // Destination match for the head word, evaluated against the current keys.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_DEST; i++) begin
            case (mem_mode[rd_ptr])
                2'b00:   match[i] = (key[i] == mem_tag[rd_ptr]);
                2'b01:   match[i] = ((key[i] ^ mem_tag[rd_ptr]) & mem_mask[rd_ptr]) == '0;
                2'b10:   match[i] = 1'b1;
                default: match[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= in_data;
            mem_tag[wr_ptr]  <= in_tag;
            mem_mask[wr_ptr] <= in_mask;
            mem_mode[wr_ptr] <= in_mode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    // Keys reset to their own index so every destination is reachable by unicast.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DEST; i++) begin
                key[i] <= TAG_WIDTH'(i);
            end
        end else begin
            for (int i = 0; i < NUM_DEST; i++) begin
                if (cfg_we && (int'(cfg_idx) == i)) begin
                    key[i] <= cfg_tag;
                end
            end
        end
    end

    // Delivery FSM. pending is latched on entry to DELIVER, so key writes made
    // while a word is in flight only affect the next head evaluation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            out_data <= '0;
            drop_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (match != '0) begin
                            pending  <= match;
                            out_data <= mem_data[rd_ptr];
                            state    <= DELIVER;
                        end else if (drop_cnt != 8'hFF) begin
                            drop_cnt <= drop_cnt + 8'd1;
                        end
                    end
                end
                DELIVER: begin
                    if (remaining == '0) begin
                        pending <= '0;
                        state   <= IDLE;
                    end else begin
                        pending <= remaining;
                    end
                end
                default: begin
                    pending <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tagged_multicaster.sv
module tb_tagged_multicaster;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [3:0]  cfg_tag = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [3:0]  in_tag = '0;
    logic [3:0]  in_mask = '0;
    logic [1:0]  in_mode = '0;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;
    logic [15:0] out_data;
    logic        busy;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    tagged_multicaster #(
        .DATA_WIDTH(16), .NUM_DEST(4), .TAG_WIDTH(4), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_tag(cfg_tag),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_tag(in_tag), .in_mask(in_mask), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference keys, reset value of key[i] is i.
    logic [3:0] mkey [4];

    function automatic logic [3:0] exp_match(input logic [3:0] tag, input logic [3:0] mask,
                                             input logic [1:0] mode);
        logic [3:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            if (mode == 2'd0)      m[i] = (mkey[i] == tag);
            else if (mode == 2'd1) m[i] = (((mkey[i] ^ tag) & mask) == 4'd0);
            else if (mode == 2'd2) m[i] = 1'b1;
            else                   m[i] = 1'b0;
        end
        return m;
    endfunction

    // Leaves the bench at posedge+1 with reset released.
    task automatic apply_reset;
        rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; out_ready = '0;
        for (int i = 0; i < 4; i++) mkey[i] = 4'(i);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic set_word(input logic [15:0] d, input logic [3:0] t,
                            input logic [3:0] m, input logic [1:0] md);
        in_valid = 1'b1; in_data = d; in_tag = t; in_mask = m; in_mode = md;
    endtask

    task automatic test_reset;
        apply_reset();
        n_checks++; if (out_valid !== 4'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0000", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
        n_checks++; if (out_data !== 16'd0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    endtask

    task automatic test_unicast;
        apply_reset();
        out_ready = 4'hF;
        set_word(16'hA5C3, 4'd2, 4'd0, 2'b00);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 4'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL uni_after_push: got vld=%b busy=%b want 0000/1", out_valid, busy); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 4'b0100) begin n_fail++; $display("FAIL uni_valid: got %b want 0100", out_valid); end
        n_checks++; if (out_data !== 16'hA5C3) begin n_fail++; $display("FAIL uni_data: got %h want a5c3", out_data); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL uni_done: got vld=%b busy=%b want 0000/0", out_valid, busy); end
    endtask

    task automatic test_masked;
        apply_reset();
        out_ready = 4'b0001;
        set_word(16'h0F0F, 4'd0, 4'b1110, 2'b01);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 4'b0011 || out_data !== 16'h0F0F) begin n_fail++; $display("FAIL mask_first: got %b/%h want 0011/0f0f", out_valid, out_data); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 4'b0010 || out_data !== 16'h0F0F) begin n_fail++; $display("FAIL mask_partial: got %b/%h want 0010/0f0f", out_valid, out_data); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mask_busy: got %b want 1", busy); end
        out_ready = 4'b0010;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mask_pop: got vld=%b busy=%b want 0000/0", out_valid, busy); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] got [$];
        logic        pushed_now;
        logic        fifth_taken;
        apply_reset();
        out_ready = 4'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_%0d: got %b want 1", k, in_ready); end
            set_word(16'(100 + k), 4'd0, 4'd0, 2'b10);
            @(posedge clk); #1;
        end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: got %b want 0", in_ready); end
        set_word(16'd104, 4'd0, 4'd0, 2'b10);
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 4'hF) begin n_fail++; $display("FAIL bp_hold: got rdy=%b vld=%b want 0/1111", in_ready, out_valid); end
        out_ready = 4'hF;
        fifth_taken = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (out_valid == 4'hF) got.push_back(out_data);
            pushed_now = in_valid && in_ready;
            @(posedge clk); #1;
            if (pushed_now) begin in_valid = 1'b0; fifth_taken = 1'b1; end
        end
        n_checks++; if (fifth_taken !== 1'b1) begin n_fail++; $display("FAIL bp_fifth: got %b want 1", fifth_taken); end
        n_checks++; if (got.size() != 5) begin n_fail++; $display("FAIL bp_count: got %0d want 5", got.size()); end
        for (int k = 0; k < 5 && k < got.size(); k++) begin
            n_checks++; if (got[k] !== 16'(100 + k)) begin n_fail++; $display("FAIL bp_word_%0d: got %0d want %0d", k, got[k], 100 + k); end
        end
    endtask

    task automatic test_drop;
        logic [3:0] seen;
        int sent;
        apply_reset();
        out_ready = 4'hF;
        set_word(16'hDEAD, 4'd9, 4'd0, 2'b00);
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = '0;
        for (int c = 0; c < 3; c++) begin @(posedge clk); #1; seen |= out_valid; end
        n_checks++; if (seen !== 4'b0) begin n_fail++; $display("FAIL drop_no_valid: got %b want 0000", seen); end
        n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL drop_one: got %0d want 1", drop_cnt); end
        sent = 0;
        set_word(16'hBEEF, 4'd9, 4'd0, 2'b00);
        for (int c = 0; c < 700 && sent < 300; c++) begin
            if (in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20 && busy; c++) begin @(posedge clk); #1; end
        n_checks++; if (sent != 300 || busy !== 1'b0) begin n_fail++; $display("FAIL drop_stream: got sent=%0d busy=%b want 300/0", sent, busy); end
        n_checks++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL drop_saturate: got %0d want 255", drop_cnt); end
    endtask

    task automatic test_cfg_during_deliver;
        apply_reset();
        out_ready = 4'b0;
        set_word(16'h1234, 4'd1, 4'd0, 2'b00);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 4'b0010) begin n_fail++; $display("FAIL cfg_a_valid: got %b want 0010", out_valid); end
        cfg_we = 1'b1; cfg_idx = 2'd3; cfg_tag = 4'd9;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        mkey[3] = 4'd9;
        n_checks++; if (out_valid !== 4'b0010 || out_data !== 16'h1234) begin n_fail++; $display("FAIL cfg_a_kept: got %b/%h want 0010/1234", out_valid, out_data); end
        out_ready = 4'hF;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 4'b0) begin n_fail++; $display("FAIL cfg_a_done: got %b want 0000", out_valid); end
        set_word(16'h5678, 4'd9, 4'd0, 2'b00);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 4'b1000 || out_data !== 16'h5678) begin n_fail++; $display("FAIL cfg_new_key: got %b/%h want 1000/5678", out_valid, out_data); end
        @(posedge clk); #1;
        set_word(16'h9999, 4'd3, 4'd0, 2'b00);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (drop_cnt !== 8'd1 || out_valid !== 4'b0) begin n_fail++; $display("FAIL cfg_old_key: got drop=%0d vld=%b want 1/0000", drop_cnt, out_valid); end
    endtask

    task automatic test_reset_mid_deliver;
        logic [3:0] seen;
        apply_reset();
        out_ready = 4'b0;
        for (int k = 0; k < 4; k++) begin
            set_word(16'(16'h0200 + k), 4'd0, 4'd0, 2'b10);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++; if (busy !== 1'b1 || out_valid !== 4'hF) begin n_fail++; $display("FAIL rstmid_setup: got busy=%b vld=%b want 1/1111", busy, out_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 4'b0 || out_data !== 16'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: got vld=%b data=%h busy=%b want 0000/0000/0", out_valid, out_data, busy); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 4'hF;
        seen = '0;
        for (int c = 0; c < 8; c++) begin @(posedge clk); #1; seen |= out_valid; end
        n_checks++; if (seen !== 4'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_stale: got seen=%b busy=%b rdy=%b want 0000/0/1", seen, busy, in_ready); end
    endtask

    task automatic test_random;
        logic [15:0] dq [4][$];
        logic [3:0]  prev_vld;
        logic [3:0]  prev_rdy;
        logic [15:0] prev_data;
        logic [3:0]  hold;
        logic [3:0]  m;
        logic [15:0] e;
        int          exp_drop;
        int          done;
        apply_reset();
        exp_drop = 0; prev_vld = '0; prev_rdy = '0; prev_data = '0; done = 0;
        for (int c = 0; c < 1200; c++) begin
            if (c < 700) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = 16'($urandom);
                in_tag    = 4'($urandom_range(0, 5));
                in_mask   = 4'($urandom);
                in_mode   = 2'($urandom);
                out_ready = 4'($urandom);
            end else begin
                in_valid  = 1'b0;
                out_ready = 4'hF;
            end
            @(negedge clk);
            hold = prev_vld & ~prev_rdy;
            if (hold != 4'b0) begin
                n_checks++;
                if ((out_valid & hold) !== hold || out_data !== prev_data) begin
                    n_fail++; $display("FAIL rnd_hold cycle %0d: got %b/%h want bits %b with data %h", c, out_valid, out_data, hold, prev_data);
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    n_checks++;
                    if (dq[i].size() == 0) begin
                        n_fail++; $display("FAIL rnd_extra dest %0d: got data %h want no delivery", i, out_data);
                    end else begin
                        e = dq[i].pop_front();
                        if (out_data !== e) begin n_fail++; $display("FAIL rnd_data dest %0d: got %h want %h", i, out_data, e); end
                    end
                end
            end
            if (in_valid && in_ready) begin
                m = exp_match(in_tag, in_mask, in_mode);
                if (m == 4'b0) exp_drop++;
                for (int i = 0; i < 4; i++) if (m[i]) dq[i].push_back(in_data);
            end
            prev_vld = out_valid; prev_rdy = out_ready; prev_data = out_data;
            @(posedge clk); #1;
            if (c >= 700 && !busy && dq[0].size() == 0 && dq[1].size() == 0 &&
                dq[2].size() == 0 && dq[3].size() == 0) begin
                done = 1;
                break;
            end
        end
        n_checks++; if (done != 1) begin n_fail++; $display("FAIL rnd_drain: got busy=%b left=%0d/%0d/%0d/%0d want idle and empty", busy, dq[0].size(), dq[1].size(), dq[2].size(), dq[3].size()); end
        if (exp_drop > 255) exp_drop = 255;
        n_checks++; if (drop_cnt !== 8'(exp_drop)) begin n_fail++; $display("FAIL rnd_drop_cnt: got %0d want %0d", drop_cnt, exp_drop); end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_masked();
        test_back_to_back();
        test_drop();
        test_cfg_during_deliver();
        test_reset_mid_deliver();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tagged_multicaster.md
TAGGED_MULTICASTER -- requirements
Module: tagged_multicaster

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, payload width.
REQ-002 SHALL have parameter NUM_DEST, default 4, number of PE destinations.
REQ-003 SHALL have parameter TAG_WIDTH, default 4, key/tag width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, input buffer entries; power of two, >=2.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port cfg_we  in  1  key write strobe.
REQ-008 SHALL have port cfg_idx  in  clog2(NUM_DEST)  destination whose key is written.
REQ-009 SHALL have port cfg_tag  in  TAG_WIDTH  key value written.
REQ-010 SHALL have port in_valid  in  1  source word valid.
REQ-011 SHALL have port in_ready  out  1  buffer can accept.
REQ-012 SHALL have port in_data  in  DATA_WIDTH  payload.
REQ-013 SHALL have port in_tag  in  TAG_WIDTH  lock tag of the word.
REQ-014 SHALL have port in_mask  in  TAG_WIDTH  compare mask; 1 = bit compared.
REQ-015 SHALL have port in_mode  in  2  00 unicast, 01 masked, 10 broadcast, 11 reserved.
REQ-016 SHALL have port out_valid  out  NUM_DEST  per-destination valid.
REQ-017 SHALL have port out_ready  in  NUM_DEST  per-destination ready.
REQ-018 SHALL have port out_data  out  DATA_WIDTH  shared payload bus to all destinations.
REQ-019 SHALL have port busy  out  1  FIFO non-empty or word in delivery.
REQ-020 SHALL have port drop_cnt  out  8  count of words matching no destination.

Function
REQ-021 SHALL keep a key register per destination; cfg_we with cfg_idx<NUM_DEST writes cfg_tag at the edge; cfg_idx>=NUM_DEST ignored.
REQ-022 SHALL buffer {data, tag, mask, mode} in a FIFO of FIFO_DEPTH entries; push on in_valid && in_ready.
REQ-023 SHALL drive in_ready = FIFO not full, independent of in_valid.
REQ-024 SHALL compute match[i]: unicast key[i]==tag; masked ((key[i]^tag)&mask)==0; broadcast 1; reserved 0.
REQ-025 SHALL implement states IDLE and DELIVER.
REQ-026 IDLE, FIFO non-empty, match of head non-zero: latch pending<=match, go DELIVER.
REQ-027 IDLE, FIFO non-empty, match all-zero: pop head, drop_cnt+1 (saturating at 255), stay IDLE.
REQ-028 DELIVER: out_valid=pending, out_data=head data; each edge pending<=pending&~(out_valid&out_ready).
REQ-029 DELIVER: when every remaining pending bit handshakes in the same cycle, pop head and return to IDLE at that edge.
REQ-030 SHALL hold out_data stable and never deassert a pending out_valid bit before its handshake.
REQ-031 Latency: word pushed into empty FIFO in IDLE at edge N drives out_valid after edge N+1; peak rate one word per 2 cycles.
REQ-032 Key writes during DELIVER SHALL not alter latched pending; they apply from the next IDLE evaluation.
REQ-033 Push and pop in the same edge SHALL both take effect; occupancy unchanged.
REQ-034 busy SHALL be 1 when state is DELIVER or FIFO non-empty.
REQ-035 out_valid SHALL be all-zero in IDLE.

Reset
REQ-036 On rst: FIFO empty, state IDLE, pending 0, out_valid 0, out_data 0, drop_cnt 0, busy 0, in_ready 1 after release.
REQ-037 On rst: key[i] = i mod 2^TAG_WIDTH.
REQ-038 rst during DELIVER SHALL discard the in-flight word and all buffered words with no further out_valid.

Verification
REQ-039 Reset, unicast tag=2, all out_ready=1 -> out_valid=0100 one cycle, out_data=payload, busy falls next cycle.
REQ-040 Masked tag=0, mask=1110, out_ready=0001 then 0010 -> out_valid 0011, then 0010, then 0000 with pop.
REQ-041 Broadcast with out_ready held 0 -> five pushes: in_ready low after 4th; fifth held until a pop.
REQ-042 Unicast tag=9 (no key 9) -> no out_valid, drop_cnt 0->1; 300 such words -> drop_cnt=255.
REQ-043 cfg write key[3]=9 during DELIVER of word A -> A pending unchanged; next tag=9 word -> out_valid=1000.
REQ-044 rst asserted mid-DELIVER with 3 words buffered -> outputs zero asynchronously, busy=0, no stale delivery after release.
